// File: rtl/boid_frame_scanner_if.sv
`default_nettype none
// ============================================================================
//  Module      : boid_frame_scanner_if
//  Description : Bundles the occupancy-check and framebuffer-write signals of
//                the boid frame scanner.
//  Revision    : 1.0 - initial release
// ============================================================================
interface boid_frame_scanner_if #(
    parameter int ADDR_W = 19
);
    logic              start;
    logic              busy;
    logic              done;
    logic [31:0]       x_chk_out;
    logic [31:0]       y_chk_out;
    logic              is_boid_here;
    logic              fb_stall;
    logic              fb_wr_en;
    logic [ADDR_W-1:0] fb_addr;
    logic [7:0]        fb_data;
    logic [15:0]       frame_count;

    // Scanner side
    modport master (
        input  start,
        input  is_boid_here,
        input  fb_stall,
        output busy,
        output done,
        output x_chk_out,
        output y_chk_out,
        output fb_wr_en,
        output fb_addr,
        output fb_data,
        output frame_count
    );

    // Environment side: controller, boid memory and framebuffer
    modport slave (
        output start,
        output is_boid_here,
        output fb_stall,
        input  busy,
        input  done,
        input  x_chk_out,
        input  y_chk_out,
        input  fb_wr_en,
        input  fb_addr,
        input  fb_data,
        input  frame_count
    );
endinterface
`default_nettype wire

// File: rtl/boid_frame_scanner.sv
`default_nettype none
// ============================================================================
//  Module      : boid_frame_scanner
//  Description : Raster-scans every pixel, queries boid occupancy and writes
//                one framebuffer byte per pixel. Optional macro
//                BOID_SCAN_FRAME_COUNT_EN enables the completed-frame counter.
//  Revision    : 1.0 - initial release
// ============================================================================
module boid_frame_scanner #(
    parameter int         H_PIXELS   = 640,
    parameter int         V_PIXELS   = 480,
    parameter int         ADDR_W     = 19,
    parameter logic [7:0] BOID_COLOR = 8'hFF,
    parameter logic [7:0] BG_COLOR   = 8'h00
) (
    input  wire logic            clk,
    input  wire logic            reset,
    boid_frame_scanner_if.master bus
);
    localparam int X_W = (H_PIXELS > 1) ? $clog2(H_PIXELS) : 1;
    localparam int Y_W = (V_PIXELS > 1) ? $clog2(V_PIXELS) : 1;
    localparam logic [X_W-1:0] C_X_LAST = X_W'(H_PIXELS - 1);
    localparam logic [Y_W-1:0] C_Y_LAST = Y_W'(V_PIXELS - 1);

    typedef enum logic [1:0] {
        ST_IDLE  = 2'd0,
        ST_SCAN  = 2'd1,
        ST_FLUSH = 2'd2,
        ST_DONE  = 2'd3
    } state_t;

    state_t            r_state;
    state_t            w_state_next;
    logic [X_W-1:0]    r_x;
    logic [Y_W-1:0]    r_y;
    logic [ADDR_W-1:0] r_addr_cnt;
    logic              r_fb_wr_en;
    logic [ADDR_W-1:0] r_fb_addr;
    logic [7:0]        r_fb_data;
    logic              w_launch;
    logic              w_step;
    logic              w_retire;
    logic              w_last_pixel;

    assign w_last_pixel = (r_x == C_X_LAST) && (r_y == C_Y_LAST);

    always_ff @(posedge clk) begin
        if (reset) begin
            r_state <= ST_IDLE;
        end else begin
            r_state <= w_state_next;
        end
    end

    // w_step is one accepted pixel; w_retire drops the final pending write
    always_comb begin
        w_state_next = r_state;
        w_launch     = 1'b0;
        w_step       = 1'b0;
        w_retire     = 1'b0;
        case (r_state)
            ST_IDLE: begin
                if (bus.start) begin
                    w_state_next = ST_SCAN;
                    w_launch     = 1'b1;
                end
            end
            ST_SCAN: begin
                if (!bus.fb_stall) begin
                    w_step = 1'b1;
                    if (w_last_pixel) begin
                        w_state_next = ST_FLUSH;
                    end
                end
            end
            ST_FLUSH: begin
                if (!bus.fb_stall) begin
                    w_retire     = 1'b1;
                    w_state_next = ST_DONE;
                end
            end
            ST_DONE: begin
                w_state_next = ST_IDLE;
            end
            default: begin
                w_state_next = ST_IDLE;
            end
        endcase
    end

    // Address tracks y*H_PIXELS+x by incrementing alongside the raster walk
    always_ff @(posedge clk) begin
        if (reset) begin
            r_x        <= '0;
            r_y        <= '0;
            r_addr_cnt <= '0;
        end else if (w_launch || w_retire) begin
            r_x        <= '0;
            r_y        <= '0;
            r_addr_cnt <= '0;
        end else if (w_step && !w_last_pixel) begin
            if (r_x == C_X_LAST) begin
                r_x <= '0;
                r_y <= r_y + Y_W'(1);
            end else begin
                r_x <= r_x + X_W'(1);
            end
            r_addr_cnt <= r_addr_cnt + ADDR_W'(1);
        end
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            r_fb_wr_en <= 1'b0;
            r_fb_addr  <= '0;
            r_fb_data  <= BG_COLOR;
        end else if (w_step) begin
            r_fb_wr_en <= 1'b1;
            r_fb_addr  <= r_addr_cnt;
            r_fb_data  <= bus.is_boid_here ? BOID_COLOR : BG_COLOR;
        end else if (w_retire) begin
            r_fb_wr_en <= 1'b0;
        end
    end

`ifdef BOID_SCAN_FRAME_COUNT_EN
    logic [15:0] r_frame_count;

    always_ff @(posedge clk) begin
        if (reset) begin
            r_frame_count <= 16'd0;
        end else if (w_retire) begin
            r_frame_count <= r_frame_count + 16'd1;
        end
    end

    assign bus.frame_count = r_frame_count;
`else
    assign bus.frame_count = 16'd0;
`endif

    assign bus.busy      = (r_state == ST_SCAN) || (r_state == ST_FLUSH);
    assign bus.done      = (r_state == ST_DONE);
    assign bus.x_chk_out = 32'(r_x);
    assign bus.y_chk_out = 32'(r_y);
    assign bus.fb_wr_en  = r_fb_wr_en;
    assign bus.fb_addr   = r_fb_addr;
    assign bus.fb_data   = r_fb_data;

endmodule
`default_nettype wire

// File: tb/tb_boid_frame_scanner.sv
`default_nettype none
// ============================================================================
//  Module      : tb_boid_frame_scanner
//  Description : Self-checking bench for boid_frame_scanner on a 4x3 frame.
//  Revision    : 1.0 - initial release
// ============================================================================
module tb_boid_frame_scanner;
    localparam int H      = 4;
    localparam int V      = 3;
    localparam int N      = H * V;
    localparam int ADDR_W = 4;

    logic clk   = 1'b0;
    logic reset = 1'b1;
    int   passed = 0;
    int   total  = 0;
    bit   boid_map [0:V-1][0:H-1];

    boid_frame_scanner_if #(.ADDR_W(ADDR_W)) bus ();

    boid_frame_scanner #(
        .H_PIXELS   (H),
        .V_PIXELS   (V),
        .ADDR_W     (ADDR_W),
        .BOID_COLOR (8'hFF),
        .BG_COLOR   (8'h00)
    ) dut (
        .clk   (clk),
        .reset (reset),
        .bus   (bus)
    );

    always #5 clk = ~clk;

    // Boid memory: combinational occupancy lookup at the presented coordinate
    always_comb begin
        bus.is_boid_here = 1'b0;
        if (bus.x_chk_out < 32'(H) && bus.y_chk_out < 32'(V)) begin
            bus.is_boid_here = boid_map[bus.y_chk_out][bus.x_chk_out];
        end
    end

    typedef struct {
        int boid_x;
        int boid_y;
        int stall_addr;
        int stall_len;
        int restart_addr;
        int exp_done_cycle;
    } vec_t;

    task automatic check(input string name, input longint act, input longint exp);
        total++;
        if (act == exp) begin
            passed++;
        end else begin
            $display("FAIL %s: got %0d, expected %0d (t=%0t)", name, act, exp, $time);
        end
    endtask

    task automatic clear_map();
        for (int yy = 0; yy < V; yy++) begin
            for (int xx = 0; xx < H; xx++) begin
                boid_map[yy][xx] = 1'b0;
            end
        end
    endtask

    // Cycle numbering: the cycle holding start is cycle 0.
    task automatic run_frame(input int stall_addr, input int stall_len,
                             input int restart_addr, input bit rand_stall,
                             output int beats, output int done_cycle,
                             output int done_pulses, output int stalls);
        int   cyc;
        int   stall_left;
        int   post;
        bit   stall_armed;
        bit   restarted;
        bit   seen_done;
        bit   held;
        logic [ADDR_W-1:0] pre_addr;
        logic [7:0]        pre_data;
        logic [31:0]       pre_x;
        int   ex;
        int   ey;
        beats       = 0;
        done_cycle  = -1;
        done_pulses = 0;
        stalls      = 0;
        stall_left  = 0;
        post        = 0;
        stall_armed = (stall_addr >= 0);
        restarted   = 1'b0;
        seen_done   = 1'b0;
        bus.fb_stall = 1'b0;
        bus.start    = 1'b1;
        @(posedge clk); #1;
        bus.start = 1'b0;
        cyc = 1;
        while (cyc < 200 && post < 3) begin
            if (bus.done) begin
                done_pulses++;
                if (!seen_done) done_cycle = cyc;
                seen_done = 1'b1;
            end
            bus.start    = 1'b0;
            bus.fb_stall = 1'b0;
            if (seen_done) begin
                post++;
            end else begin
                if (stall_armed && bus.fb_wr_en && int'(bus.fb_addr) == stall_addr) begin
                    stall_left  = stall_len;
                    stall_armed = 1'b0;
                end
                if (rand_stall) begin
                    bus.fb_stall = ($urandom_range(0, 2) == 0);
                end else if (stall_left > 0) begin
                    bus.fb_stall = 1'b1;
                    stall_left--;
                end
                if (bus.fb_stall) stalls++;
                if (restart_addr >= 0 && !restarted && bus.fb_wr_en &&
                    int'(bus.fb_addr) == restart_addr) begin
                    bus.start = 1'b1;
                    restarted = 1'b1;
                end
            end
            @(negedge clk);
            held     = bus.fb_stall && bus.fb_wr_en;
            pre_addr = bus.fb_addr;
            pre_data = bus.fb_data;
            pre_x    = bus.x_chk_out;
            if (bus.fb_wr_en && !bus.fb_stall) begin
                if (beats < N) begin
                    ex = beats % H;
                    ey = beats / H;
                    check("beat_addr", bus.fb_addr, beats);
                    check("beat_data", bus.fb_data, boid_map[ey][ex] ? 8'hFF : 8'h00);
                end else begin
                    check("extra_beat", beats, N - 1);
                end
                beats++;
            end
            @(posedge clk); #1;
            cyc++;
            if (held) begin
                check("stall_hold_we", bus.fb_wr_en, 1);
                check("stall_hold_addr", bus.fb_addr, pre_addr);
                check("stall_hold_data", bus.fb_data, pre_data);
                check("stall_hold_x", bus.x_chk_out, pre_x);
            end
        end
        bus.fb_stall = 1'b0;
        bus.start    = 1'b0;
    endtask

    task automatic check_frame_end(input int beats, input int done_cycle,
                                   input int done_pulses, input int exp_done);
        check("beat_count", beats, N);
        check("done_cycle", done_cycle, exp_done);
        check("done_pulses", done_pulses, 1);
        check("idle_busy", bus.busy, 0);
        check("idle_x", bus.x_chk_out, 0);
        check("idle_y", bus.y_chk_out, 0);
    endtask

    initial begin
        vec_t vecs [6];
        int   beats;
        int   done_cycle;
        int   done_pulses;
        int   stalls;
        int   n;
        int   exp_fc;

        vecs[0] = '{-1, -1, -1, 0, -1, N + 2};  // empty frame
        vecs[1] = '{ 2,  1, -1, 0, -1, N + 2};  // single boid at addr 6
        vecs[2] = '{-1, -1,  5, 3, -1, N + 5};  // 3-cycle stall on addr 5
        vecs[3] = '{-1, -1, -1, 0,  4, N + 2};  // stray start mid-frame
        vecs[4] = '{ 0,  0, -1, 0, -1, N + 2};  // first pixel
        vecs[5] = '{ 3,  2, 11, 2, -1, N + 4};  // last pixel, stalled in flush

        clear_map();
        bus.start    = 1'b0;
        bus.fb_stall = 1'b0;
        reset        = 1'b1;
        repeat (3) @(posedge clk);
        #1;
        check("rst_wr_en", bus.fb_wr_en, 0);
        check("rst_busy", bus.busy, 0);
        check("rst_done", bus.done, 0);
        check("rst_addr", bus.fb_addr, 0);
        check("rst_data", bus.fb_data, 8'h00);
        check("rst_x", bus.x_chk_out, 0);
        check("rst_y", bus.y_chk_out, 0);
        check("rst_frame_count", bus.frame_count, 0);
        reset = 1'b0;
        @(posedge clk); #1;

        for (int i = 0; i < 6; i++) begin
            clear_map();
            if (vecs[i].boid_x >= 0) boid_map[vecs[i].boid_y][vecs[i].boid_x] = 1'b1;
            run_frame(vecs[i].stall_addr, vecs[i].stall_len, vecs[i].restart_addr, 1'b0,
                      beats, done_cycle, done_pulses, stalls);
            check_frame_end(beats, done_cycle, done_pulses, vecs[i].exp_done_cycle);
        end

        for (int r = 0; r < 4; r++) begin
            for (int yy = 0; yy < V; yy++) begin
                for (int xx = 0; xx < H; xx++) begin
                    boid_map[yy][xx] = 1'($urandom_range(0, 1));
                end
            end
            run_frame(-1, 0, -1, 1'b1, beats, done_cycle, done_pulses, stalls);
            check_frame_end(beats, done_cycle, done_pulses, N + 2 + stalls);
        end

        // Reset mid-frame abandons the frame
        clear_map();
        bus.start = 1'b1;
        @(posedge clk); #1;
        bus.start = 1'b0;
        n = 0;
        while (!(bus.fb_wr_en && int'(bus.fb_addr) == 7) && n < 50) begin
            @(posedge clk); #1;
            n++;
        end
        check("reach_addr7", (bus.fb_wr_en && int'(bus.fb_addr) == 7) ? 1 : 0, 1);
        reset = 1'b1;
        @(posedge clk); #1;
        reset = 1'b0;
        check("midrst_wr_en", bus.fb_wr_en, 0);
        check("midrst_busy", bus.busy, 0);
        check("midrst_done", bus.done, 0);
        check("midrst_x", bus.x_chk_out, 0);
        check("midrst_frame_count", bus.frame_count, 0);
        repeat (3) @(posedge clk);
        #1;
        check("midrst_stays_idle", bus.busy, 0);
        check("midrst_no_write", bus.fb_wr_en, 0);

        // Rescan from addr 0, then two more frames for the frame counter
        boid_map[1][2] = 1'b1;
        for (int f = 0; f < 3; f++) begin
            run_frame(-1, 0, -1, 1'b0, beats, done_cycle, done_pulses, stalls);
            check_frame_end(beats, done_cycle, done_pulses, N + 2);
        end
`ifdef BOID_SCAN_FRAME_COUNT_EN
        exp_fc = 3;
`else
        exp_fc = 0;
`endif
        check("frame_count", bus.frame_count, exp_fc);

        $display("%0d/%0d checks passed", passed, total);
        $finish;
    end

endmodule
`default_nettype wire
